// File: rtl/mux_rr_n.sv
// N-channel registered mux with fixed-select or round-robin arbitration.
// Define MUX_PARITY_EN to add a registered out_parity output.
module mux_rr_n #(
    parameter int  NUM_CH = 4,
    parameter int  DATA_W = 4,
    localparam int SEL_W  = $clog2(NUM_CH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     mode,
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH-1:0]        in_valid,
    output logic [NUM_CH-1:0]        in_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic [SEL_W-1:0]         out_ch,
    output logic                     out_valid,
`ifdef MUX_PARITY_EN
    output logic                     out_parity,
`endif
    input  logic                     out_ready
);

    typedef enum logic {
        EMPTY = 1'b0,
        FULL  = 1'b1
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic [SEL_W-1:0]  ch_q, ch_d;
    logic [SEL_W-1:0]  last_q, last_d;
`ifdef MUX_PARITY_EN
    logic              parity_q, parity_d;
`endif

    logic              load_en;
    logic              gnt_vld;
    logic [SEL_W-1:0]  gnt_idx;
    logic [DATA_W-1:0] gnt_data;

    assign load_en = (state_q == EMPTY) || out_ready;

    // RR search is split into two passes: channels above last, then wrap.
    always_comb begin
        gnt_vld  = 1'b0;
        gnt_idx  = '0;
        gnt_data = '0;
        if (mode) begin
            for (int i = 0; i < NUM_CH; i++) begin
                if (!gnt_vld && in_valid[i] && (SEL_W'(i) > last_q)) begin
                    gnt_vld  = 1'b1;
                    gnt_idx  = SEL_W'(i);
                    gnt_data = in_data[i*DATA_W +: DATA_W];
                end
            end
            for (int i = 0; i < NUM_CH; i++) begin
                if (!gnt_vld && in_valid[i] && (SEL_W'(i) <= last_q)) begin
                    gnt_vld  = 1'b1;
                    gnt_idx  = SEL_W'(i);
                    gnt_data = in_data[i*DATA_W +: DATA_W];
                end
            end
        end else begin
            for (int i = 0; i < NUM_CH; i++) begin
                if ((sel == SEL_W'(i)) && in_valid[i]) begin
                    gnt_vld  = 1'b1;
                    gnt_idx  = SEL_W'(i);
                    gnt_data = in_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    always_comb begin
        in_ready = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            in_ready[i] = load_en && gnt_vld && (gnt_idx == SEL_W'(i));
        end
    end

    always_comb begin
        state_d  = state_q;
        data_d   = data_q;
        ch_d     = ch_q;
        last_d   = last_q;
`ifdef MUX_PARITY_EN
        parity_d = parity_q;
`endif
        if (load_en) begin
            state_d = gnt_vld ? FULL : EMPTY;
            if (gnt_vld) begin
                data_d = gnt_data;
                ch_d   = gnt_idx;
`ifdef MUX_PARITY_EN
                parity_d = ^gnt_data;
`endif
                if (mode) begin
                    last_d = gnt_idx;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= EMPTY;
            data_q   <= '0;
            ch_q     <= '0;
            last_q   <= SEL_W'(NUM_CH - 1);
`ifdef MUX_PARITY_EN
            parity_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            data_q   <= data_d;
            ch_q     <= ch_d;
            last_q   <= last_d;
`ifdef MUX_PARITY_EN
            parity_q <= parity_d;
`endif
        end
    end

    assign out_valid  = (state_q == FULL);
    assign out_data   = data_q;
    assign out_ch     = ch_q;
`ifdef MUX_PARITY_EN
    assign out_parity = parity_q;
`endif

endmodule
